// File: rtl/csp_pkg.sv
// csp_pkg: shared winner encoding, default payload width and output-stage states.
package csp_pkg;
  localparam int DEFAULT_WIDTH = 1;
  localparam logic WIN_R1 = 1'b0;
  localparam logic WIN_R2 = 1'b1;
  typedef enum logic {EMPTY, FULL} stage_e;
endpackage

// File: rtl/csp_arbiter_if.sv
// csp_arbiter_if: two request channels plus the winner channel of the arbiter.
interface csp_arbiter_if import csp_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH) ();
  logic r1_valid, r1_ready, r2_valid, r2_ready;
  logic [WIDTH-1:0] r1_data, r2_data, win_data;
  logic win_valid, win, win_ready;
  modport slave (
    input r1_valid, r1_data, r2_valid, r2_data, win_ready,
    output r1_ready, r2_ready, win_valid, win, win_data
  );
  modport master (
    output r1_valid, r1_data, r2_valid, r2_data, win_ready,
    input r1_ready, r2_ready, win_valid, win, win_data
  );
endinterface

// File: rtl/token_sink.sv
// token_sink: always-ready consumer that keeps the last token and a wrapping 16-bit token count.
module token_sink import csp_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic [WIDTH-1:0] d,
  output logic [15:0]      count
);
  logic [WIDTH-1:0] d_q, d_d;
  logic [15:0] count_q, count_d;
  assign ready = reset;
  always_comb begin
    d_d = (valid && ready) ? data : d_q;
    count_d = (valid && ready) ? count_q + 16'd1 : count_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      d_q <= '0;
      count_q <= '0;
    end else begin
      d_q <= d_d;
      count_q <= count_d;
    end
  assign d = d_q;
  assign count = count_q;
endmodule

// File: rtl/csp_arbiter.sv
// csp_arbiter: round-robin two-way arbiter feeding a one-entry winner register.
module csp_arbiter import csp_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH) (
  input logic          clk,
  input logic          reset,
  csp_arbiter_if.slave bus
);
  stage_e stage_q, stage_d;
  logic win_q, win_d, ptr_q, ptr_d, can_acc, g1, g2;
  logic [WIDTH-1:0] data_q, data_d;
  // Grants are masked by reset so both readies stay low while it is asserted.
  always_comb begin
    can_acc = stage_q == EMPTY || bus.win_ready;
    g1 = reset && can_acc && bus.r1_valid && (!bus.r2_valid || ptr_q == WIN_R1);
    g2 = reset && can_acc && bus.r2_valid && (!bus.r1_valid || ptr_q == WIN_R2);
    stage_d = (g1 || g2) ? FULL : bus.win_ready ? EMPTY : stage_q;
    win_d = g2 ? WIN_R2 : g1 ? WIN_R1 : win_q;
    data_d = g2 ? bus.r2_data : g1 ? bus.r1_data : data_q;
    ptr_d = g1 ? WIN_R2 : g2 ? WIN_R1 : ptr_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      stage_q <= EMPTY;
      win_q <= WIN_R1;
      data_q <= '0;
      ptr_q <= WIN_R1;
    end else begin
      stage_q <= stage_d;
      win_q <= win_d;
      data_q <= data_d;
      ptr_q <= ptr_d;
    end
  assign bus.r1_ready = g1;
  assign bus.r2_ready = g2;
  assign bus.win_valid = stage_q == FULL;
  assign bus.win = win_q;
  assign bus.win_data = data_q;
endmodule

// File: tb/tb_csp_arbiter.sv
// tb_csp_arbiter: random and directed traffic checked against a queue-based arbitration model.
module tb_csp_arbiter;
  import csp_pkg::*;
  localparam int W = 4;
  logic clk = 0, reset = 0, wr = 0, s_ready;
  logic [W:0] s_d;
  logic [15:0] s_count;
  int n_cmp = 0, n_err = 0;
  logic [W:0] out_q[$];
  int pref = 1, m_cnt = 0;
  bit p1 = 0, p2 = 0;
  logic [W-1:0] d1 = '0, d2 = '0;
  logic [W:0] m_d = '0;
  csp_arbiter_if #(.WIDTH(W)) bus ();
  csp_arbiter #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
  token_sink #(.WIDTH(W + 1)) sink (
    .clk(clk), .reset(reset), .valid(bus.win_valid && wr), .data({bus.win, bus.win_data}),
    .ready(s_ready), .d(s_d), .count(s_count)
  );
  assign bus.win_ready = wr & s_ready;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask
  task automatic cycle(input bit w, input bit n1, input bit n2);
    int pick;
    bit can;
    @(negedge clk);
    if (n1 && !p1) begin p1 = 1; d1 = W'($urandom); end
    if (n2 && !p2) begin p2 = 1; d2 = W'($urandom); end
    wr = w;
    bus.r1_valid = p1; bus.r1_data = d1;
    bus.r2_valid = p2; bus.r2_data = d2;
    #1;
    can = out_q.size() == 0 || w;
    pick = !can ? 0 : (p1 && p2) ? pref : p1 ? 1 : p2 ? 2 : 0;
    chk("r1_ready", 32'(bus.r1_ready), 32'(pick == 1));
    chk("r2_ready", 32'(bus.r2_ready), 32'(pick == 2));
    chk("win_valid", 32'(bus.win_valid), 32'(out_q.size() != 0));
    if (out_q.size() != 0) chk("win_token", 32'({bus.win, bus.win_data}), 32'(out_q[0]));
    chk("sink_count", 32'(s_count), 32'(m_cnt[15:0]));
    chk("sink_d", 32'(s_d), 32'(m_d));
    if (out_q.size() != 0 && w) begin m_d = out_q.pop_front(); m_cnt++; end
    if (pick == 1) begin out_q.push_back({WIN_R1, d1}); p1 = 0; pref = 2; end
    if (pick == 2) begin out_q.push_back({WIN_R2, d2}); p2 = 0; pref = 1; end
  endtask
  task automatic model_reset();
    out_q.delete();
    pref = 1; m_cnt = 0; m_d = '0;
  endtask
  initial begin
    p1 = 1; p2 = 1; d1 = W'(1); d2 = W'(1); wr = 1;
    bus.r1_valid = 1; bus.r1_data = d1; bus.r2_valid = 1; bus.r2_data = d2;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_win_valid", 32'(bus.win_valid), 0);
      chk("rst_r1_ready", 32'(bus.r1_ready), 0);
      chk("rst_r2_ready", 32'(bus.r2_ready), 0);
      chk("rst_sink_ready", 32'(s_ready), 0);
    end
    #1 reset = 1;
    model_reset();
    repeat (3) cycle(1, 0, 0);
    cycle(1, 1, 1);
    repeat (3) cycle(1, 0, 0);
    cycle(1, 1, 0);
    repeat (3) cycle(1, 0, 0);
    repeat (4) cycle(0, 1, 1);
    repeat (4) cycle(1, 0, 0);
    repeat (3000) cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    repeat (2) cycle(0, 1, 1);
    @(negedge clk); #2;
    reset = 0; #1;
    chk("midrst_win_valid", 32'(bus.win_valid), 0);
    chk("midrst_r1_ready", 32'(bus.r1_ready), 0);
    chk("midrst_r2_ready", 32'(bus.r2_ready), 0);
    chk("midrst_count", 32'(s_count), 0);
    model_reset();
    @(posedge clk); @(posedge clk); #2;
    reset = 1;
    cycle(1, 1, 1);
    repeat (4) cycle(1, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
